// File: rtl/conv_pkg.sv
// Shared definitions for the convolution input loader and the datapath header decode.
// Holds bus widths, legal image dimension range, the end-of-data marker word and the
// loader state encoding.
package conv_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int DIM_W  = 5;

  localparam logic [DIM_W-1:0]  MIN_DIM    = 5'd3;   // 3x3 kernel needs at least 3
  localparam logic [DIM_W-1:0]  MAX_DIM    = 5'd16;  // one row must fit a 16-bit word
  localparam logic [DATA_W-1:0] END_MARKER = 16'h00FF;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_HDR_R,
    LD_HDR_C,
    LD_STREAM,
    LD_ROW_WR,
    LD_MARK,
    LD_DONE
  } ld_state_e;
endpackage

// File: rtl/conv_input_loader_if.sv
// Pixel stream handshake and input-SRAM write port of the loader.
//   pix_valid/pix_data  : bit-serial pixel source -> loader
//   pix_ready           : loader accepts pix_data this cycle
//   loader_sram_write_* : address/data/strobe toward the input SRAM
// slave = loader side, master = source/SRAM side.
interface conv_input_loader_if;
  import conv_pkg::*;
  logic              pix_valid;
  logic              pix_data;
  logic              pix_ready;
  logic [ADDR_W-1:0] loader_sram_write_address;
  logic [DATA_W-1:0] loader_sram_write_data;
  logic              loader_sram_write_enable;

  modport slave (
    input  pix_valid, pix_data,
    output pix_ready, loader_sram_write_address, loader_sram_write_data,
           loader_sram_write_enable
  );
  modport master (
    output pix_valid, pix_data,
    input  pix_ready, loader_sram_write_address, loader_sram_write_data,
           loader_sram_write_enable
  );
endinterface

// File: rtl/conv_row_packer.sv
// Collects one image row from the bit-serial stream into a 16-bit word, pixel c in bit c.
//   clk, reset_b : clock, async active-low reset
//   beat_i       : a pixel is accepted this cycle
//   pix_i        : the accepted pixel
//   clr_i        : clear word and column counter (row has been written)
//   ncols_m1_i   : latched column count minus one
//   word_nxt_o   : row word including this cycle's pixel (feeds the write register)
//   row_done_o   : this beat carries the last column of the row
module conv_row_packer import conv_pkg::*; (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              beat_i,
  input  logic              pix_i,
  input  logic              clr_i,
  input  logic [DIM_W-1:0]  ncols_m1_i,
  output logic [DATA_W-1:0] word_nxt_o,
  output logic              row_done_o
);
  localparam int IDX_W = $clog2(DATA_W);

  logic [DIM_W-1:0]  col_q;
  logic [DATA_W-1:0] word_q, bit_d;

  always_comb begin
    bit_d = '0;
    bit_d[col_q[IDX_W-1:0]] = pix_i;
  end

  assign word_nxt_o = word_q | (beat_i ? bit_d : '0);
  assign row_done_o = beat_i && (col_q == ncols_m1_i);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      col_q  <= '0;
      word_q <= '0;
    end else if (clr_i) begin
      col_q  <= '0;
      word_q <= '0;
    end else if (beat_i) begin
      col_q  <= col_q + DIM_W'(1);
      word_q <= word_nxt_o;
    end
  end
endmodule

// File: rtl/conv_input_loader.sv
// Writer side of the convolution input SRAM. One image per load_start is streamed in
// bit-serially and written as [nrows][ncols][row0..rowN-1], optionally followed by
// END_MARKER. Images pack back to back; the write pointer only returns to BASE_ADDR on reset.
//   clk, reset_b          : clock, async active-low reset
//   load_start            : 1-cycle start pulse, samples img_nrows/img_ncols/img_last
//   load_busy, load_error : status (error is sticky until the next legal start)
//   bus (slave)           : pixel handshake + SRAM write port
// Every output is registered. The write registers are loaded on entry to a writing state
// so the strobe is visible during that state (row word lands the cycle after its last pixel).
module conv_input_loader import conv_pkg::*; #(
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 12'h000,
  parameter logic [DATA_W-1:0] END_MARKER = conv_pkg::END_MARKER,
  parameter logic [DIM_W-1:0]  MIN_DIM    = conv_pkg::MIN_DIM,
  parameter logic [DIM_W-1:0]  MAX_DIM    = conv_pkg::MAX_DIM
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             load_start,
  input  logic [DIM_W-1:0] img_nrows,
  input  logic [DIM_W-1:0] img_ncols,
  input  logic             img_last,
  output logic             load_busy,
  output logic             load_error,
  conv_input_loader_if.slave bus
);
  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d, word_nxt;
  logic [DIM_W-1:0]  nrows_q, nrows_d, ncols_q, ncols_d, row_q, row_d, ncols_m1;
  logic              we_q, we_d, ready_q, ready_d, busy_q, busy_d, err_q, err_d;
  logic              last_q, last_d, beat, row_done, start_ok;

  assign start_ok = (img_nrows >= MIN_DIM) && (img_nrows <= MAX_DIM) &&
                    (img_ncols >= MIN_DIM) && (img_ncols <= MAX_DIM);
  assign beat     = ready_q && bus.pix_valid;
  assign ncols_m1 = ncols_q - DIM_W'(1);

  conv_row_packer u_packer (
    .clk        (clk),
    .reset_b    (reset_b),
    .beat_i     (beat),
    .pix_i      (bus.pix_data),
    .clr_i      (state_q == LD_ROW_WR),
    .ncols_m1_i (ncols_m1),
    .word_nxt_o (word_nxt),
    .row_done_o (row_done)
  );

  always_comb begin
    state_d = state_q;
    nrows_d = nrows_q;
    ncols_d = ncols_q;
    row_d   = row_q;
    last_d  = last_q;
    err_d   = err_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    unique case (state_q)
      LD_IDLE: if (load_start) begin
        if (start_ok) begin
          nrows_d = img_nrows;
          ncols_d = img_ncols;
          last_d  = img_last;
          row_d   = '0;
          err_d   = 1'b0;
          state_d = LD_HDR_R;
        end else begin
          err_d   = 1'b1;
        end
      end
      LD_HDR_R:  state_d = LD_HDR_C;
      LD_HDR_C:  state_d = LD_STREAM;
      LD_STREAM: if (row_done) state_d = LD_ROW_WR;
      LD_ROW_WR: begin
        row_d = row_q + DIM_W'(1);
        if (row_q == nrows_q - DIM_W'(1)) state_d = last_q ? LD_MARK : LD_DONE;
        else                              state_d = LD_STREAM;
      end
      LD_MARK:   state_d = LD_DONE;
      LD_DONE:   state_d = LD_IDLE;
      default:   state_d = LD_IDLE;
    endcase

    // Writing states last exactly one cycle, so landing in one means a fresh write.
    unique case (state_d)
      LD_HDR_R:  begin we_d = 1'b1; data_d = {{(DATA_W-DIM_W){1'b0}}, nrows_d}; end
      LD_HDR_C:  begin we_d = 1'b1; data_d = {{(DATA_W-DIM_W){1'b0}}, ncols_q}; end
      LD_ROW_WR: begin we_d = 1'b1; data_d = word_nxt; end
      LD_MARK:   begin we_d = 1'b1; data_d = END_MARKER; end
      default: ;
    endcase
    if (we_d) begin
      addr_d = ptr_q;
      ptr_d  = ptr_q + ADDR_W'(1);  // wraps silently at the top of the SRAM
    end

    ready_d = (state_d == LD_STREAM);
    busy_d  = (state_d != LD_IDLE) && (state_d != LD_DONE);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= LD_IDLE;
      ptr_q   <= BASE_ADDR;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      nrows_q <= '0;
      ncols_q <= '0;
      row_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      nrows_q <= nrows_d;
      ncols_q <= ncols_d;
      row_q   <= row_d;
      last_q  <= last_d;
    end
  end

  assign bus.pix_ready                 = ready_q;
  assign bus.loader_sram_write_address = addr_q;
  assign bus.loader_sram_write_data    = data_q;
  assign bus.loader_sram_write_enable  = we_q;
  assign load_busy                     = busy_q;
  assign load_error                    = err_q;
endmodule
